// File: rtl/cla_pkg.sv
// Shared helpers for the pipelined carry-lookahead adder: group
// propagate/generate reductions and the parameter legality check.
package cla_pkg;

  // Widest lookahead group the helper functions can reduce.
  localparam int CLA_MAX_GROUP = 64;

  // Group propagate: a carry entering bit 0 passes through bits [n-1:0].
  function automatic logic cla_group_p(input logic [CLA_MAX_GROUP-1:0] p,
                                       input int n);
    logic acc;
    acc = 1'b1;
    for (int i = 0; i < CLA_MAX_GROUP; i++) begin
      if (i < n) acc = acc & p[i];
    end
    return acc;
  endfunction

  // Group generate: bits [n-1:0] produce a carry out on their own.
  function automatic logic cla_group_g(input logic [CLA_MAX_GROUP-1:0] p,
                                       input logic [CLA_MAX_GROUP-1:0] g,
                                       input int n);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < CLA_MAX_GROUP; i++) begin
      if (i < n) acc = g[i] | (p[i] & acc);
    end
    return acc;
  endfunction

  // WIDTH must split into whole groups, and a group must fit the helpers.
  function automatic bit cla_params_ok(input int width, input int group);
    return (group >= 1) && (group <= CLA_MAX_GROUP) &&
           (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group_adder.sv
// Combinational GROUP-bit carry-lookahead adder. Every internal carry is
// formed directly from prefix propagate/generate terms and the group
// carry-in, so depth does not grow as a ripple chain.
module cla_group_adder
  import cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] x,
  input  logic [GROUP-1:0] y,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             p,
  output logic             g,
  output logic             c_msb
);

  logic [GROUP-1:0]         w_pb;
  logic [GROUP-1:0]         w_gb;
  logic [CLA_MAX_GROUP-1:0] w_p_ext;
  logic [CLA_MAX_GROUP-1:0] w_g_ext;
  logic [GROUP:0]           w_c;

  assign w_pb = x ^ y;
  assign w_gb = x & y;

  // Lookahead carries: c[i] = G[i-1:0] | P[i-1:0] & cin.
  always_comb begin
    w_p_ext = '0;
    w_g_ext = '0;
    w_p_ext[GROUP-1:0] = w_pb;
    w_g_ext[GROUP-1:0] = w_gb;
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 1; i <= GROUP; i++) begin
      w_c[i] = cla_group_g(w_p_ext, w_g_ext, i) |
               (cla_group_p(w_p_ext, i) & cin);
    end
  end

  assign s     = w_pb ^ w_c[GROUP-1:0];
  assign cout  = w_c[GROUP];
  assign c_msb = w_c[GROUP-1];
  assign p     = cla_group_p(w_p_ext, GROUP);
  assign g     = cla_group_g(w_p_ext, w_g_ext, GROUP);

endmodule

// File: rtl/pipelined_cla_adder.sv
// Carry-pipelined adder/subtractor: one GROUP-bit lookahead group is
// resolved per stage, the group carry and the untouched upper operand bits
// travel down the pipe. A global stall freezes every stage when the
// result at the output is not taken.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NGROUPS = WIDTH / GROUP;

  if (!cla_params_ok(WIDTH, GROUP)) begin : g_bad_params
    $fatal(1, "pipelined_cla_adder: WIDTH must be a nonzero multiple of GROUP");
  end

  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // Subtraction is A + ~B + 1; the caller's carry-in is ignored then.
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : c_in;

  // Every stage moves together; a held output freezes the whole pipe.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_stage
    localparam int LO = k * GROUP;
    localparam int HI = LO + GROUP - 1;

    logic [GROUP-1:0] w_x;
    logic [GROUP-1:0] w_y;
    logic             w_cin;
    logic [GROUP-1:0] w_s;
    logic             w_cout;
    logic             w_p;
    logic             w_g;
    logic             w_cmsb;
    logic             w_vld_in;
    logic [HI:0]      w_sum_next;
    logic             r_vld;
    logic [HI:0]      r_sum;

    // Stage 0 reads the ports; later stages read the previous stage's regs.
    if (k == 0) begin : g_src
      assign w_x        = a[HI:LO];
      assign w_y        = w_b_eff[HI:LO];
      assign w_cin      = w_cin_eff;
      assign w_vld_in   = in_valid;
      assign w_sum_next = w_s;
    end else begin : g_src
      assign w_x        = g_stage[k-1].g_hi.r_a_hi[HI:LO];
      assign w_y        = g_stage[k-1].g_hi.r_b_hi[HI:LO];
      assign w_cin      = g_stage[k-1].g_hi.r_carry;
      assign w_vld_in   = g_stage[k-1].r_vld;
      assign w_sum_next = {w_s, g_stage[k-1].r_sum};
    end

    cla_group_adder #(
      .GROUP (GROUP)
    ) u_group (
      .x     (w_x),
      .y     (w_y),
      .cin   (w_cin),
      .s     (w_s),
      .cout  (w_cout),
      .p     (w_p),
      .g     (w_g),
      .c_msb (w_cmsb)
    );

    // Stage k boundary: valid bit and the sum bits finished so far.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_vld <= 1'b0;
        r_sum <= '0;
      end else if (w_advance) begin
        r_vld <= w_vld_in;
        r_sum <= w_sum_next;
      end
    end

    if (k < NGROUPS - 1) begin : g_hi
      logic [WIDTH-1:HI+1] w_a_src;
      logic [WIDTH-1:HI+1] w_b_src;
      logic [WIDTH-1:HI+1] r_a_hi;
      logic [WIDTH-1:HI+1] r_b_hi;
      logic                r_carry;
      logic                w_unused_grp;

      // Group flags and MSB carry only matter at the top of the word.
      assign w_unused_grp = &{1'b0, w_p, w_g, w_cmsb};

      if (k == 0) begin : g_ops
        assign w_a_src = a[WIDTH-1:HI+1];
        assign w_b_src = w_b_eff[WIDTH-1:HI+1];
      end else begin : g_ops
        assign w_a_src = g_stage[k-1].g_hi.r_a_hi[WIDTH-1:HI+1];
        assign w_b_src = g_stage[k-1].g_hi.r_b_hi[WIDTH-1:HI+1];
      end

      // Carry into group k+1 and the operand bits still to be summed.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_a_hi  <= '0;
          r_b_hi  <= '0;
          r_carry <= 1'b0;
        end else if (w_advance) begin
          r_a_hi  <= w_a_src;
          r_b_hi  <= w_b_src;
          r_carry <= w_cout;
        end
      end
    end else begin : g_last
      logic r_cout;
      logic r_ovf;
      logic r_zero;
      logic w_unused_grp;

      assign w_unused_grp = &{1'b0, w_p, w_g};

      // Final stage: status flags registered beside the completed sum.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_advance) begin
          r_cout <= w_cout;
          r_ovf  <= w_cout ^ w_cmsb;
          r_zero <= (w_sum_next == '0);
        end
      end
    end
  end

  assign out_valid = g_stage[NGROUPS-1].r_vld;
  assign s         = g_stage[NGROUPS-1].r_sum;
  assign c_out     = g_stage[NGROUPS-1].g_last.r_cout;
  assign ovf       = g_stage[NGROUPS-1].g_last.r_ovf;
  assign zero      = g_stage[NGROUPS-1].g_last.r_zero;

endmodule
